// File: rtl/lsu_data_master_if.sv
`default_nettype none
// ============================================================================
// Interface : lsu_data_master_if
// Brief     : Request/response channels of the load/store unit and the
//             read/write bus of the dual-port data memory.
// Revision  : 1.0 - initial release
// ============================================================================
interface lsu_data_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // request channel (execute stage -> LSU)
  logic                  pReq_bValid;
  logic                  pReq_bReady;
  logic                  pReq_bWrite;
  logic [2:0]            pReq_bFunct3;
  logic [ADDR_WIDTH-1:0] pReq_bAddr;
  logic [DATA_WIDTH-1:0] pReq_bData;
  // response channel (LSU -> pipeline)
  logic                  pResp_bValid;
  logic                  pResp_bReady;
  logic [DATA_WIDTH-1:0] pResp_bData;
  logic                  pResp_bErr;
  // data-memory bus
  logic                  pMemData_pRd_bEn;
  logic [ADDR_WIDTH-1:0] pMemData_pRd_bAddr;
  logic [DATA_WIDTH-1:0] pMemData_pRd_bData;
  logic                  pMemData_pWr_bEn;
  logic [ADDR_WIDTH-1:0] pMemData_pWr_bAddr;
  logic [DATA_WIDTH-1:0] pMemData_pWr_bData;
  logic                  pMemData_pWr_bMask_0;
  logic                  pMemData_pWr_bMask_1;
  logic                  pMemData_pWr_bMask_2;
  logic                  pMemData_pWr_bMask_3;

  // LSU side
  modport master (
    input  pReq_bValid, pReq_bWrite, pReq_bFunct3, pReq_bAddr, pReq_bData,
    output pReq_bReady,
    output pResp_bValid, pResp_bData, pResp_bErr,
    input  pResp_bReady,
    output pMemData_pRd_bEn, pMemData_pRd_bAddr,
    input  pMemData_pRd_bData,
    output pMemData_pWr_bEn, pMemData_pWr_bAddr, pMemData_pWr_bData,
    output pMemData_pWr_bMask_0, pMemData_pWr_bMask_1,
    output pMemData_pWr_bMask_2, pMemData_pWr_bMask_3
  );

  // pipeline + memory side
  modport slave (
    output pReq_bValid, pReq_bWrite, pReq_bFunct3, pReq_bAddr, pReq_bData,
    input  pReq_bReady,
    input  pResp_bValid, pResp_bData, pResp_bErr,
    output pResp_bReady,
    input  pMemData_pRd_bEn, pMemData_pRd_bAddr,
    output pMemData_pRd_bData,
    input  pMemData_pWr_bEn, pMemData_pWr_bAddr, pMemData_pWr_bData,
    input  pMemData_pWr_bMask_0, pMemData_pWr_bMask_1,
    input  pMemData_pWr_bMask_2, pMemData_pWr_bMask_3
  );
endinterface
`default_nettype wire

// File: rtl/lsu_data_master.sv
`default_nettype none
// ============================================================================
// Module   : lsu_data_master
// Brief    : Load/store initiator for the data-memory port. Accepts one
//            request at a time, checks size/alignment, performs a single
//            cycle memory access and returns a sign/zero-extended result.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_data_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32    // four byte lanes assumed throughout
) (
  input  wire logic         clock,
  input  wire logic         reset,
  lsu_data_master_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic                  req_fire;
  logic                  req_legal;

  // request fields kept for the access/response phases
  logic                  lat_write;
  logic [2:0]            lat_funct3;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] load_ext;

  // memory-side next values and their registers; the bus only ever sees
  // flop outputs so nothing toggles between clock edges
  logic                  rd_en_d,   rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_d, rd_addr_q;
  logic                  wr_en_d,   wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_d, wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_d, wr_data_q;
  logic [3:0]            mask_d,    mask_q;     // {mask_0..mask_3}

  assign req_fire = (state == S_IDLE) && bus.pReq_bValid;
  assign rd_word  = bus.pMemData_pRd_bData;

  // Classify the incoming request: unknown funct3, unsigned store, misalignment
  always_comb begin
    req_legal = 1'b1;
    case (bus.pReq_bFunct3)
      3'b000:  req_legal = 1'b1;
      3'b001:  req_legal = !bus.pReq_bAddr[0];
      3'b010:  req_legal = (bus.pReq_bAddr[1:0] == 2'b00);
      3'b100:  req_legal = !bus.pReq_bWrite;
      3'b101:  req_legal = !bus.pReq_bWrite && !bus.pReq_bAddr[0];
      default: req_legal = 1'b0;
    endcase
  end

  // Extend the returned word according to the latched access size
  always_comb begin
    load_ext = rd_word;
    case (lat_funct3)
      3'b000:  load_ext = {{(DATA_WIDTH-8){rd_word[7]}}, rd_word[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){rd_word[15]}}, rd_word[15:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, rd_word[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, rd_word[15:0]};
      default: load_ext = rd_word;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state: illegal requests skip the access cycle entirely
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (bus.pReq_bValid) state_next = req_legal ? S_ACCESS : S_RESP;
      S_ACCESS: state_next = S_RESP;
      S_RESP:   if (bus.pResp_bReady) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Outputs: handshake flags and the memory fields to load on the accept edge
  always_comb begin
    bus.pReq_bReady  = (state == S_IDLE) && !reset;
    bus.pResp_bValid = (state == S_RESP);
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    mask_d    = 4'b0000;
    if (req_fire && req_legal) begin
      if (bus.pReq_bWrite) begin
        wr_en_d   = 1'b1;
        wr_addr_d = bus.pReq_bAddr;
        wr_data_d = bus.pReq_bData;
        case (bus.pReq_bFunct3[1:0])
          2'b00:   mask_d = 4'b0001;
          2'b01:   mask_d = 4'b0011;
          default: mask_d = 4'b1111;
        endcase
      end else begin
        rd_en_d   = 1'b1;
        rd_addr_d = bus.pReq_bAddr;
      end
    end
  end

  // Memory-side registers: set for exactly the ACCESS cycle, cleared otherwise
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      mask_q    <= 4'b0000;
    end else begin
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      mask_q    <= mask_d;
    end
  end

  // Latch the request, then capture the load result at the end of ACCESS
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_write  <= 1'b0;
      lat_funct3 <= 3'b000;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else if (req_fire) begin
      lat_write  <= bus.pReq_bWrite;
      lat_funct3 <= bus.pReq_bFunct3;
      resp_data  <= '0;
      resp_err   <= !req_legal;
    end else if ((state == S_ACCESS) && !lat_write) begin
      resp_data  <= load_ext;
    end
  end

  assign bus.pMemData_pRd_bEn     = rd_en_q;
  assign bus.pMemData_pRd_bAddr   = rd_addr_q;
  assign bus.pMemData_pWr_bEn     = wr_en_q;
  assign bus.pMemData_pWr_bAddr   = wr_addr_q;
  assign bus.pMemData_pWr_bData   = wr_data_q;
  assign bus.pMemData_pWr_bMask_0 = mask_q[3];
  assign bus.pMemData_pWr_bMask_1 = mask_q[2];
  assign bus.pMemData_pWr_bMask_2 = mask_q[1];
  assign bus.pMemData_pWr_bMask_3 = mask_q[0];
  assign bus.pResp_bData          = resp_data;
  assign bus.pResp_bErr           = resp_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_data_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_data_master
// Brief    : Directed and random load/store traffic for lsu_data_master,
//            compared cycle by cycle against a byte-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_data_master;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int MEM_BYTES = 1024;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  lsu_data_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  lsu_data_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // memory seen by the DUT, and the model's own copy
  logic [7:0] mem     [0:MEM_BYTES-1];
  logic [7:0] ref_mem [0:MEM_BYTES-1];

  function automatic int idx(input logic [31:0] a, input int off);
    return (int'(a[9:0]) + off) % MEM_BYTES;
  endfunction

  // little-endian combinational read port
  always_comb begin
    bus.pMemData_pRd_bData = {mem[idx(bus.pMemData_pRd_bAddr, 3)], mem[idx(bus.pMemData_pRd_bAddr, 2)],
                              mem[idx(bus.pMemData_pRd_bAddr, 1)], mem[idx(bus.pMemData_pRd_bAddr, 0)]};
  end

  logic [3:0] act_mask;
  assign act_mask = {bus.pMemData_pWr_bMask_0, bus.pMemData_pWr_bMask_1,
                     bus.pMemData_pWr_bMask_2, bus.pMemData_pWr_bMask_3};

  // write port: the mask is a length code, bytes go to addr, addr+1, ...
  always @(posedge clock) begin
    if (bus.pMemData_pWr_bEn) begin
      for (int i = 0; i < 4; i++)
        if (i < $countones(act_mask))
          mem[idx(bus.pMemData_pWr_bAddr, i)] = bus.pMemData_pWr_bData[8*i +: 8];
    end
  end

  // ---------------- reference model ----------------
  function automatic bit model_legal(input bit w, input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000:  return 1'b1;
      3'b001:  return (a % 2) == 0;
      3'b010:  return (a % 4) == 0;
      3'b100:  return !w;
      3'b101:  return !w && ((a % 2) == 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    int unsigned v;
    w = {ref_mem[idx(a, 3)], ref_mem[idx(a, 2)], ref_mem[idx(a, 1)], ref_mem[idx(a, 0)]};
    case (f3)
      3'b000:  begin v = w % 256;   return (v >= 128)   ? 32'(v) - 32'd256   : 32'(v); end
      3'b001:  begin v = w % 65536; return (v >= 32768) ? 32'(v) - 32'd65536 : 32'(v); end
      3'b010:  return w;
      3'b100:  return w % 256;
      3'b101:  return w % 65536;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < nbytes(f3); i++) ref_mem[idx(a, i)] = d[8*i +: 8];
  endtask

  // ---------------- per-cycle expectations ----------------
  typedef struct {
    int          txn;
    logic        req_ready, rd_en, wr_en, resp_valid, resp_err;
    logic [31:0] rd_addr, wr_addr, wr_data, resp_data;
    logic [3:0]  mask;
    bit          chk_rd_addr, chk_wr, chk_resp;
  } exp_t;

  exp_t expq[$];
  exp_t cur;
  bit   bad;
  int   checks = 0;
  int   errors = 0;
  int   txn_no = 0;
  logic [31:0] last_resp_data = '0;
  logic        last_resp_err  = 1'b0;

  function automatic exp_t quiet_rec(input logic ready);
    exp_t e;
    e.txn = txn_no;       e.req_ready = ready;  e.rd_en = 1'b0;  e.wr_en = 1'b0;
    e.resp_valid = 1'b0;  e.resp_err = 1'b0;    e.rd_addr = '0;  e.wr_addr = '0;
    e.wr_data = '0;       e.resp_data = '0;     e.mask = 4'b0000;
    e.chk_rd_addr = 1'b1; e.chk_wr = 1'b1;      e.chk_resp = 1'b0;
    return e;
  endfunction

  // Compare DUT outputs with the expectation queued for this cycle
  always @(negedge clock) begin
    if (!reset && expq.size() > 0) begin
      cur = expq.pop_front();
      checks++;
      bad = (bus.pReq_bReady !== cur.req_ready) || (bus.pMemData_pRd_bEn !== cur.rd_en) ||
            (bus.pMemData_pWr_bEn !== cur.wr_en) || (bus.pResp_bValid !== cur.resp_valid) ||
            (cur.chk_rd_addr && (bus.pMemData_pRd_bAddr !== cur.rd_addr)) ||
            (cur.chk_wr && ((bus.pMemData_pWr_bAddr !== cur.wr_addr) ||
                            (bus.pMemData_pWr_bData !== cur.wr_data) || (act_mask !== cur.mask))) ||
            (cur.chk_resp && ((bus.pResp_bData !== cur.resp_data) || (bus.pResp_bErr !== cur.resp_err)));
      if (bad) begin
        errors++;
        $display("FAIL cycle txn=%0d got rdy=%b rd=%b@%h wr=%b@%h d=%h m=%b rv=%b data=%h err=%b want rdy=%b rd=%b@%h wr=%b@%h d=%h m=%b rv=%b data=%h err=%b",
                 cur.txn, bus.pReq_bReady, bus.pMemData_pRd_bEn, bus.pMemData_pRd_bAddr,
                 bus.pMemData_pWr_bEn, bus.pMemData_pWr_bAddr, bus.pMemData_pWr_bData, act_mask,
                 bus.pResp_bValid, bus.pResp_bData, bus.pResp_bErr,
                 cur.req_ready, cur.rd_en, cur.rd_addr, cur.wr_en, cur.wr_addr, cur.wr_data, cur.mask,
                 cur.resp_valid, cur.resp_data, cur.resp_err);
      end
      if (bus.pResp_bValid) begin
        last_resp_data = bus.pResp_bData;
        last_resp_err  = bus.pResp_bErr;
      end
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic step(input exp_t e);
    expq.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic junk_request();
    bus.pReq_bValid  = 1'($urandom);
    bus.pReq_bWrite  = 1'($urandom);
    bus.pReq_bFunct3 = 3'($urandom);
    bus.pReq_bAddr   = $urandom;
    bus.pReq_bData   = $urandom;
  endtask

  // One full transaction: request, optional access, response with stall cycles
  task automatic txn(input bit w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input int stall, input int idle_after);
    exp_t e;
    bit legal;
    logic [31:0] rdata;
    txn_no++;
    legal = model_legal(w, f3, a);
    rdata = '0;
    bus.pReq_bValid  = 1'b1;
    bus.pReq_bWrite  = w;
    bus.pReq_bFunct3 = f3;
    bus.pReq_bAddr   = a;
    bus.pReq_bData   = d;
    bus.pResp_bReady = 1'($urandom);
    step(quiet_rec(1'b1));
    junk_request();
    if (legal) begin
      e = quiet_rec(1'b0);
      if (w) begin
        e.wr_en = 1'b1; e.wr_addr = a; e.wr_data = d;
        e.mask = 4'((1 << nbytes(f3)) - 1);
        e.chk_rd_addr = 1'b0;
        model_store(f3, a, d);
      end else begin
        e.rd_en = 1'b1; e.rd_addr = a;
        e.chk_wr = 1'b0;
        rdata = model_load(f3, a);
      end
      step(e);
    end
    for (int i = 0; i <= stall; i++) begin
      bus.pResp_bReady = (i == stall);
      junk_request();
      e = quiet_rec(1'b0);
      e.resp_valid = 1'b1; e.resp_data = rdata; e.resp_err = !legal; e.chk_resp = 1'b1;
      step(e);
    end
    bus.pReq_bValid  = 1'b0;
    bus.pResp_bReady = 1'b0;
    for (int i = 0; i < idle_after; i++) step(quiet_rec(1'b1));
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  b;
    bus.pReq_bValid = 1'b0; bus.pReq_bWrite = 1'b0; bus.pReq_bFunct3 = 3'b000;
    bus.pReq_bAddr = '0; bus.pReq_bData = '0; bus.pResp_bReady = 1'b0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      b = 8'($urandom);
      mem[i] = b;
      ref_mem[i] = b;
    end
    a = 32'h8badf00d;
    for (int i = 0; i < 4; i++) begin mem['h010 + i] = a[8*i +: 8]; ref_mem['h010 + i] = a[8*i +: 8]; end
    a = 32'h000080F0;
    for (int i = 0; i < 4; i++) begin mem['h100 + i] = a[8*i +: 8]; ref_mem['h100 + i] = a[8*i +: 8]; end

    #1 reset = 1'b1;
    #2;
    check32("reset_outputs",
            {24'd0, bus.pReq_bReady, bus.pResp_bValid, bus.pResp_bErr, bus.pMemData_pRd_bEn,
             bus.pMemData_pWr_bEn, (|act_mask), (|bus.pMemData_pWr_bAddr), (|bus.pMemData_pRd_bAddr)}, 32'd0);
    check32("reset_resp_data", bus.pResp_bData, 32'd0);
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;
    step(quiet_rec(1'b1));

    // pin the model to hand-computed values
    check32("model_lw",  model_load(3'b010, 32'h80000010), 32'h8badf00d);
    check32("model_lb",  model_load(3'b000, 32'h100), 32'hFFFFFFF0);
    check32("model_lbu", model_load(3'b100, 32'h100), 32'h000000F0);
    check32("model_lh",  model_load(3'b001, 32'h100), 32'hFFFF80F0);
    check32("model_lhu", model_load(3'b101, 32'h100), 32'h000080F0);

    // directed: loads and extension
    txn(1'b0, 3'b010, 32'h80000010, 32'h0, 0, 1); check32("lw_result", last_resp_data, 32'h8badf00d);
    txn(1'b0, 3'b000, 32'h100, 32'h0, 0, 0);      check32("lb_result", last_resp_data, 32'hFFFFFFF0);
    txn(1'b0, 3'b100, 32'h100, 32'h0, 0, 0);      check32("lbu_result", last_resp_data, 32'h000000F0);
    txn(1'b0, 3'b001, 32'h100, 32'h0, 0, 0);      check32("lh_result", last_resp_data, 32'hFFFF80F0);
    txn(1'b0, 3'b101, 32'h100, 32'h0, 0, 1);      check32("lhu_result", last_resp_data, 32'h000080F0);

    // directed: stores
    txn(1'b1, 3'b000, 32'h200, 32'h11223344, 0, 0);
    check32("sb_mem_byte", {24'd0, mem['h200]}, 32'h44);
    check32("sb_resp", {last_resp_data[30:0], last_resp_err}, 32'd0);
    txn(1'b1, 3'b001, 32'h200, 32'h11223344, 0, 0);
    txn(1'b1, 3'b010, 32'h200, 32'h11223344, 1, 0);
    txn(1'b0, 3'b010, 32'h200, 32'h0, 0, 0);      check32("sw_readback", last_resp_data, 32'h11223344);

    // directed: illegal requests
    txn(1'b0, 3'b010, 32'h202, 32'h0, 0, 0);      check32("lw_misaligned_err", {31'd0, last_resp_err}, 32'd1);
    txn(1'b1, 3'b001, 32'h201, 32'h5555AAAA, 0, 0); check32("sh_misaligned_err", {31'd0, last_resp_err}, 32'd1);
    txn(1'b1, 3'b100, 32'h204, 32'h5555AAAA, 0, 0); check32("store_f3_100_err", {31'd0, last_resp_err}, 32'd1);

    // directed: backpressure
    txn(1'b0, 3'b010, 32'h80000010, 32'h0, 5, 1);

    // random traffic concentrated in a 64-byte window so loads see earlier stores
    for (int n = 0; n < 250; n++) begin
      a = $urandom;
      a[9:0] = 10'h300 + 10'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      txn(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // reset during the access cycle of a store
    bus.pReq_bValid = 1'b1; bus.pReq_bWrite = 1'b1; bus.pReq_bFunct3 = 3'b010;
    bus.pReq_bAddr = 32'h240; bus.pReq_bData = 32'hCAFEBABE;
    @(posedge clock); #1;
    bus.pReq_bValid = 1'b0;
    check32("sw_access_wr_en", {31'd0, bus.pMemData_pWr_bEn}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check32("reset_drops_wr_en", {31'd0, bus.pMemData_pWr_bEn}, 32'd0);
    check32("reset_clears_wr_addr", bus.pMemData_pWr_bAddr, 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check32("after_reset_idle", {29'd0, bus.pReq_bReady, bus.pResp_bValid, bus.pMemData_pWr_bEn}, 32'b100);
    @(negedge clock);
    check32("after_reset_no_resp", {31'd0, bus.pResp_bValid}, 32'd0);
    check32("reset_store_dropped", {24'd0, mem[idx(32'h240, 0)]}, {24'd0, ref_mem[idx(32'h240, 0)]});
    @(posedge clock); #1;

    // operation resumes normally
    txn(1'b0, 3'b010, 32'h80000010, 32'h0, 0, 1); check32("post_reset_lw", last_resp_data, 32'h8badf00d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
